multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle RV32I control sequencer. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes. It handshakes with a variable-latency memory, with a parametrised wait timeout and trap handling. It sits beside the shared single-cycle decode tables and is the core's top-level controller for the multi-cycle build.

Parameters:
MEM_TIMEOUT, 0, max wait cycles for memReady in FETCH/MEM before bus-error trap; 0 = wait forever
TRAP_HALT, 0, 1 = remain in TRAP until reset; 0 = single TRAP cycle then FETCH

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
op  in  5  instr[6:2] from instruction register
funct3  in  3  instr[14:12] from instruction register
brTaken  in  1  branch comparator result, valid in EXEC
memReady  in  1  memory completes current request this cycle
memReq  out  1  memory request, held until memReady
memWe  out  1  write qualifier for memReq
addrSel  out  1  memory address source: 0 PC, 1 ALU result
irWrite  out  1  load instruction register
pcWrite  out  1  update PC
pcSrc  out  1  0 PC+4, 1 ALU target
regWrite  out  1  register-file write enable
regSrc  out  2  0 ALU, 1 MEM, 2 PC+4 link, 3 CSR
immCntrl  out  3  immediate type (shared encoding)
aluSrcA  out  2  0 rs1, 1 PC, 3 zero
aluSrcB  out  1  1 = immediate
useF7  out  1  ALU honours funct7
instRetired  out  1  one-cycle pulse at instruction completion
illegalOp  out  1  one-cycle pulse on TRAP entry for illegal opcode
busErr  out  1  one-cycle pulse on TRAP entry for memory timeout

Behaviour:
- Reset: state = FETCH, wait counter = 0. All outputs 0 except those FETCH drives (memReq = 1, addrSel = 0). Reset mid-request abandons it; memReady during rst is ignored.
- FETCH: memReq = 1, addrSel = 0. On memReady: irWrite = 1, pcWrite = 1, pcSrc = 0, go to DECODE.
- DECODE: immCntrl, aluSrcA, aluSrcB and useF7 are decoded from op/funct3 using the shared tables.
  - Shift immediates (funct3[1:0] = 01 on the I-arith opcode) use SHAMT with useF7 = 1.
  - JAL uses J; JALR uses I.
  - AUIPC selects aluSrcA = PC; LUI selects aluSrcA = zero.
  - aluSrcB = (immCntrl != DEFAULT) and not branch.
  - Illegal op goes to TRAP; otherwise go to EXEC.
- Decode outputs are held stable in DECODE, EXEC, MEM and WB; they are 0 in FETCH and TRAP.
- EXEC:
  - Branch: pcWrite = brTaken, pcSrc = 1, instRetired = 1, go to FETCH.
  - JAL/JALR: regWrite = 1, regSrc = 2, pcWrite = 1, pcSrc = 1, instRetired = 1, go to FETCH.
  - Load/store: go to MEM.
  - R, I-arith, AUIPC, LUI: go to WB.
- MEM: memReq = 1, addrSel = 1, memWe = store. On memReady: a load goes to WB; a store pulses instRetired and goes to FETCH.
- WB: regWrite = 1, regSrc = 1 for load, 0 otherwise; instRetired = 1; go to FETCH.
- TRAP: illegalOp or busErr is high for the entry cycle only. Next state is TRAP if TRAP_HALT, else FETCH. PC is not modified.
- Timeout: the counter clears on entry to FETCH or MEM and increments each cycle memReady is low there.
  - When the counter equals MEM_TIMEOUT-1 and memReady is still low: go to TRAP with busErr.
  - memReady arriving in that same cycle wins; no trap.
  - Counter width is $clog2(MEM_TIMEOUT+1), minimum 1.
- memReady outside FETCH/MEM is ignored.
- Latency: ALU op 4 cycles, load 5, store 4, branch/jump 3 (zero-wait memory).

Optional Feature:
MCU_CSR_EN:
- Defined: op 11100 is legal. EXEC goes to WB with regSrc = 3 and immCntrl = I; funct3 = 000 (ECALL/EBREAK) goes to TRAP with illegalOp.
- Undefined: op 11100 is illegal and goes to TRAP.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams;
  - IMM_TYPE_*, regSrc and aluSrcA encodings;
  - state enum typedef (FETCH, DECODE, EXEC, MEM, WB, TRAP).
- Sub-module insn_decode: the combinational op/funct3 to immCntrl/aluSrcA/aluSrcB/useF7/legal/class mapping, shared with the single-cycle core.

Test Plan:
- addi x1,x0,5 (op 00100, funct3 000), memReady every request → irWrite at cycle 1; immCntrl = 010, aluSrcB = 1 in cycles 2-3; regWrite and instRetired at cycle 4.
- lw, memReady low 3 cycles in MEM, MEM_TIMEOUT = 8 → memReq stays high for 4 cycles; regWrite with regSrc = 1 the cycle after memReady.
- beq with brTaken = 0, then again with brTaken = 1 → pcWrite = 0 then pcWrite = 1, pcSrc = 1; 3 cycles each.
- op 11111 → illegalOp pulses one cycle. TRAP_HALT = 0 gives memReq the next cycle; TRAP_HALT = 1 keeps memReq = 0 until rst.
- MEM_TIMEOUT = 4, memReady never asserted in FETCH → busErr pulses on cycle 4. With memReady at cycle 3 exactly, no busErr.
- rst asserted mid-MEM store → next cycle state = FETCH, memWe = 0, no instRetired; with and without MCU_CSR_EN, op 11100/funct3 001 → WB with regSrc = 3, or illegalOp.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller and its decode tables.
// MCU_CSR_EN makes the SYSTEM opcode (CSR access) legal.
package ctrl_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  localparam logic [2:0] IMM_TYPE_DEFAULT = 3'd0;
  localparam logic [2:0] IMM_TYPE_SHAMT   = 3'd1;
  localparam logic [2:0] IMM_TYPE_I       = 3'd2;
  localparam logic [2:0] IMM_TYPE_S       = 3'd3;
  localparam logic [2:0] IMM_TYPE_B       = 3'd4;
  localparam logic [2:0] IMM_TYPE_U       = 3'd5;
  localparam logic [2:0] IMM_TYPE_J       = 3'd6;

  localparam logic [1:0] REG_SRC_ALU  = 2'd0;
  localparam logic [1:0] REG_SRC_MEM  = 2'd1;
  localparam logic [1:0] REG_SRC_LINK = 2'd2;
  localparam logic [1:0] REG_SRC_CSR  = 2'd3;

  localparam logic [1:0] ALU_A_RS1  = 2'd0;
  localparam logic [1:0] ALU_A_PC   = 2'd1;
  localparam logic [1:0] ALU_A_ZERO = 2'd3;

`ifdef MCU_CSR_EN
  localparam bit CSR_EN = 1'b1;
`else
  localparam bit CSR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_CSR, CLS_ENV
  } insn_class_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory handshake between the controller (master) and the memory port (slave).
interface multicycle_ctrl_if;
  logic memReq;
  logic memWe;
  logic addrSel;
  logic memReady;

  modport master (output memReq, output memWe, output addrSel, input memReady);
  modport slave  (input memReq, input memWe, input addrSel, output memReady);
endinterface

// File: rtl/multicycle_ctrl_insn_decode.sv
// Combinational op/funct3 decode shared with the single-cycle core.
// SYSTEM opcode legality follows MCU_CSR_EN (via ctrl_pkg::CSR_EN).
module insn_decode
  import ctrl_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [2:0]  funct3,
  output logic [2:0]  immCntrl,
  output logic [1:0]  aluSrcA,
  output logic        aluSrcB,
  output logic        useF7,
  output logic        legal,
  output insn_class_t iclass
);

  always_comb begin
    immCntrl = IMM_TYPE_DEFAULT;
    aluSrcA  = ALU_A_RS1;
    useF7    = 1'b0;
    legal    = 1'b1;
    iclass   = CLS_ALU;
    case (op)
      OP_LOAD:   begin immCntrl = IMM_TYPE_I; iclass = CLS_LOAD; end
      OP_STORE:  begin immCntrl = IMM_TYPE_S; iclass = CLS_STORE; end
      OP_IMM: begin
        if (funct3[1:0] == 2'b01) begin
          immCntrl = IMM_TYPE_SHAMT;
          useF7    = 1'b1;
        end else begin
          immCntrl = IMM_TYPE_I;
        end
      end
      OP_OP:     useF7 = 1'b1;
      OP_AUIPC:  begin immCntrl = IMM_TYPE_U; aluSrcA = ALU_A_PC; end
      OP_LUI:    begin immCntrl = IMM_TYPE_U; aluSrcA = ALU_A_ZERO; end
      OP_BRANCH: begin immCntrl = IMM_TYPE_B; iclass = CLS_BRANCH; end
      OP_JAL:    begin immCntrl = IMM_TYPE_J; aluSrcA = ALU_A_PC; iclass = CLS_JUMP; end
      OP_JALR:   begin immCntrl = IMM_TYPE_I; iclass = CLS_JUMP; end
      OP_SYSTEM: begin
        // funct3 == 000 is ECALL/EBREAK, which traps instead of accessing a CSR
        legal    = CSR_EN;
        immCntrl = CSR_EN ? IMM_TYPE_I : IMM_TYPE_DEFAULT;
        iclass   = (funct3 == 3'b000) ? CLS_ENV : CLS_CSR;
      end
      default:   legal = 1'b0;
    endcase
    aluSrcB = (immCntrl != IMM_TYPE_DEFAULT) && (iclass != CLS_BRANCH);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer with memory wait timeout and traps.
// Optional CSR/SYSTEM support enabled by defining MCU_CSR_EN.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter bit          TRAP_HALT   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus,
  input  logic [4:0]        op,
  input  logic [2:0]        funct3,
  input  logic              brTaken,
  output logic              irWrite,
  output logic              pcWrite,
  output logic              pcSrc,
  output logic              regWrite,
  output logic [1:0]        regSrc,
  output logic [2:0]        immCntrl,
  output logic [1:0]        aluSrcA,
  output logic              aluSrcB,
  output logic              useF7,
  output logic              instRetired,
  output logic              illegalOp,
  output logic              busErr
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] wcnt;
  logic             ready, timeout, dec_active, trap_ill, trap_bus;
  logic [2:0]       dec_imm;
  logic [1:0]       dec_srca;
  logic             dec_srcb, dec_f7, dec_legal;
  insn_class_t      dec_class;

  insn_decode u_dec (
    .op       (op),
    .funct3   (funct3),
    .immCntrl (dec_imm),
    .aluSrcA  (dec_srca),
    .aluSrcB  (dec_srcb),
    .useF7    (dec_f7),
    .legal    (dec_legal),
    .iclass   (dec_class)
  );

  always_comb begin
    state_n     = state;
    bus.memReq  = 1'b0;
    bus.memWe   = 1'b0;
    bus.addrSel = 1'b0;
    irWrite     = 1'b0;
    pcWrite     = 1'b0;
    pcSrc       = 1'b0;
    regWrite    = 1'b0;
    regSrc      = REG_SRC_ALU;
    instRetired = 1'b0;
    trap_ill    = 1'b0;
    trap_bus    = 1'b0;
    ready       = bus.memReady & ~rst;
    // memReady on the last permitted wait cycle wins over the timeout
    timeout     = (MEM_TIMEOUT != 0) && !ready && (wcnt == CNT_LAST);
    dec_active  = state inside {DECODE, EXEC, MEM, WB};
    immCntrl    = dec_active ? dec_imm  : '0;
    aluSrcA     = dec_active ? dec_srca : '0;
    aluSrcB     = dec_active && dec_srcb;
    useF7       = dec_active && dec_f7;
    case (state)
      FETCH: begin
        bus.memReq = 1'b1;
        if (ready) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_n = DECODE;
        end else if (timeout) begin
          trap_bus = 1'b1;
          state_n  = TRAP;
        end
      end
      DECODE: begin
        if (dec_legal) state_n = EXEC;
        else begin
          trap_ill = 1'b1;
          state_n  = TRAP;
        end
      end
      EXEC: begin
        case (dec_class)
          CLS_BRANCH: begin
            pcWrite = brTaken; pcSrc = 1'b1; instRetired = 1'b1; state_n = FETCH;
          end
          CLS_JUMP: begin
            regWrite = 1'b1; regSrc = REG_SRC_LINK; pcWrite = 1'b1; pcSrc = 1'b1;
            instRetired = 1'b1; state_n = FETCH;
          end
          CLS_LOAD, CLS_STORE: state_n = MEM;
          CLS_ENV: begin trap_ill = 1'b1; state_n = TRAP; end
          default: state_n = WB;
        endcase
      end
      MEM: begin
        bus.memReq  = 1'b1;
        bus.addrSel = 1'b1;
        bus.memWe   = (dec_class == CLS_STORE);
        if (ready) begin
          if (dec_class == CLS_STORE) begin
            instRetired = 1'b1;
            state_n     = FETCH;
          end else begin
            state_n = WB;
          end
        end else if (timeout) begin
          trap_bus = 1'b1;
          state_n  = TRAP;
        end
      end
      WB: begin
        regWrite    = 1'b1;
        instRetired = 1'b1;
        state_n     = FETCH;
        if (dec_class == CLS_LOAD)     regSrc = REG_SRC_MEM;
        else if (dec_class == CLS_CSR) regSrc = REG_SRC_CSR;
      end
      TRAP:    state_n = TRAP_HALT ? TRAP : FETCH;
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      wcnt      <= '0;
      illegalOp <= 1'b0;
      busErr    <= 1'b0;
    end else begin
      state     <= state_n;
      illegalOp <= trap_ill;
      busErr    <= trap_bus;
      if (state_n != state) wcnt <= '0;
      else if ((MEM_TIMEOUT != 0) && !ready && (state == FETCH || state == MEM))
        wcnt <= wcnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: dut A (MEM_TIMEOUT=4, TRAP_HALT=0), dut B (MEM_TIMEOUT=8, TRAP_HALT=1).
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rsta, rstb, brTaken;
  logic [4:0] op;
  logic [2:0] funct3;
  int n_tests = 0;
  int n_fail  = 0;

  multicycle_ctrl_if ifa ();
  multicycle_ctrl_if ifb ();

  logic a_irWrite, a_pcWrite, a_pcSrc, a_regWrite, a_aluSrcB, a_useF7, a_ret, a_ill, a_berr;
  logic [1:0] a_regSrc, a_aluSrcA;
  logic [2:0] a_imm;
  logic b_irWrite, b_pcWrite, b_pcSrc, b_regWrite, b_aluSrcB, b_useF7, b_ret, b_ill, b_berr;
  logic [1:0] b_regSrc, b_aluSrcA;
  logic [2:0] b_imm;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .TRAP_HALT(1'b0)) ua (
    .clk(clk), .rst(rsta), .bus(ifa), .op(op), .funct3(funct3), .brTaken(brTaken),
    .irWrite(a_irWrite), .pcWrite(a_pcWrite), .pcSrc(a_pcSrc), .regWrite(a_regWrite),
    .regSrc(a_regSrc), .immCntrl(a_imm), .aluSrcA(a_aluSrcA), .aluSrcB(a_aluSrcB),
    .useF7(a_useF7), .instRetired(a_ret), .illegalOp(a_ill), .busErr(a_berr)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(8), .TRAP_HALT(1'b1)) ub (
    .clk(clk), .rst(rstb), .bus(ifb), .op(op), .funct3(funct3), .brTaken(brTaken),
    .irWrite(b_irWrite), .pcWrite(b_pcWrite), .pcSrc(b_pcSrc), .regWrite(b_regWrite),
    .regSrc(b_regSrc), .immCntrl(b_imm), .aluSrcA(b_aluSrcA), .aluSrcB(b_aluSrcB),
    .useF7(b_useF7), .instRetired(b_ret), .illegalOp(b_ill), .busErr(b_berr)
  );

  typedef struct {
    logic [4:0] op;
    logic [2:0] f3;
    logic [2:0] imm;
    logic [1:0] srca;
    logic       srcb;
    logic       f7;
  } alu_vec_t;

  // addi, slli, srai, sltiu, add, auipc, lui
  alu_vec_t av [7] = '{
    '{5'b00100, 3'b000, 3'd2, 2'd0, 1'b1, 1'b0},
    '{5'b00100, 3'b001, 3'd1, 2'd0, 1'b1, 1'b1},
    '{5'b00100, 3'b101, 3'd1, 2'd0, 1'b1, 1'b1},
    '{5'b00100, 3'b011, 3'd2, 2'd0, 1'b1, 1'b0},
    '{5'b01100, 3'b000, 3'd0, 2'd0, 1'b0, 1'b1},
    '{5'b00101, 3'b000, 3'd5, 2'd1, 1'b1, 1'b0},
    '{5'b01101, 3'b000, 3'd5, 2'd3, 1'b1, 1'b0}
  };

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rsta = 1'b1; rstb = 1'b1; brTaken = 1'b0; op = '0; funct3 = '0;
    ifa.memReady = 1'b1; ifb.memReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset: FETCH outputs only, memReady ignored while rst is high
    chk("rst memReq", ifa.memReq, 1);
    chk("rst addrSel", ifa.addrSel, 0);
    chk("rst irWrite", a_irWrite, 0);
    chk("rst pcWrite", a_pcWrite, 0);
    chk("rst regWrite", a_regWrite, 0);
    chk("rst immCntrl", a_imm, 0);
    chk("rst illegalOp", a_ill, 0);
    rsta = 1'b0;

    // ALU-class instructions: FETCH, DECODE, EXEC, WB
    for (int i = 0; i < 7; i++) begin
      op = av[i].op; funct3 = av[i].f3; ifa.memReady = 1'b1; #1;
      chk($sformatf("alu%0d fetch irWrite", i), a_irWrite, 1);
      chk($sformatf("alu%0d fetch pcSrc", i), a_pcSrc, 0);
      chk($sformatf("alu%0d fetch immCntrl", i), a_imm, 0);
      cyc(); ifa.memReady = 1'b0; #1;
      chk($sformatf("alu%0d dec immCntrl", i), a_imm, av[i].imm);
      chk($sformatf("alu%0d dec aluSrcA", i), a_aluSrcA, av[i].srca);
      chk($sformatf("alu%0d dec aluSrcB", i), a_aluSrcB, av[i].srcb);
      chk($sformatf("alu%0d dec useF7", i), a_useF7, av[i].f7);
      chk($sformatf("alu%0d dec memReq", i), ifa.memReq, 0);
      cyc();
      chk($sformatf("alu%0d exec immCntrl", i), a_imm, av[i].imm);
      chk($sformatf("alu%0d exec regWrite", i), a_regWrite, 0);
      cyc();
      chk($sformatf("alu%0d wb regWrite", i), a_regWrite, 1);
      chk($sformatf("alu%0d wb regSrc", i), a_regSrc, 0);
      chk($sformatf("alu%0d wb instRetired", i), a_ret, 1);
      cyc();
      chk($sformatf("alu%0d next memReq", i), ifa.memReq, 1);
      chk($sformatf("alu%0d next instRetired", i), a_ret, 0);
    end

    // beq not taken then taken: 3 cycles each
    op = 5'b11000; funct3 = 3'b000;
    for (int t = 0; t < 2; t++) begin
      brTaken = (t == 1); ifa.memReady = 1'b1; #1;
      cyc(); ifa.memReady = 1'b0; #1;
      chk($sformatf("br%0d dec immCntrl", t), a_imm, 4);
      chk($sformatf("br%0d dec aluSrcB", t), a_aluSrcB, 0);
      cyc();
      chk($sformatf("br%0d exec pcWrite", t), a_pcWrite, (t == 1) ? 8'd1 : 8'd0);
      chk($sformatf("br%0d exec pcSrc", t), a_pcSrc, 1);
      chk($sformatf("br%0d exec instRetired", t), a_ret, 1);
      chk($sformatf("br%0d exec regWrite", t), a_regWrite, 0);
      cyc();
      chk($sformatf("br%0d next memReq", t), ifa.memReq, 1);
    end
    brTaken = 1'b0;

    // JAL then JALR
    for (int j = 0; j < 2; j++) begin
      op = (j == 0) ? 5'b11011 : 5'b11001; funct3 = 3'b000; ifa.memReady = 1'b1; #1;
      cyc(); ifa.memReady = 1'b0; #1;
      chk($sformatf("jmp%0d dec immCntrl", j), a_imm, (j == 0) ? 8'd6 : 8'd2);
      chk($sformatf("jmp%0d dec aluSrcA", j), a_aluSrcA, (j == 0) ? 8'd1 : 8'd0);
      chk($sformatf("jmp%0d dec aluSrcB", j), a_aluSrcB, 1);
      cyc();
      chk($sformatf("jmp%0d exec regWrite", j), a_regWrite, 1);
      chk($sformatf("jmp%0d exec regSrc", j), a_regSrc, 2);
      chk($sformatf("jmp%0d exec pcWrite", j), a_pcWrite, 1);
      chk($sformatf("jmp%0d exec pcSrc", j), a_pcSrc, 1);
      chk($sformatf("jmp%0d exec instRetired", j), a_ret, 1);
      cyc();
      chk($sformatf("jmp%0d next memReq", j), ifa.memReq, 1);
    end

    // sw, zero-wait memory: 4 cycles
    op = 5'b01000; funct3 = 3'b010; ifa.memReady = 1'b1; #1;
    cyc(); ifa.memReady = 1'b0; #1;
    chk("sw dec immCntrl", a_imm, 3);
    cyc();
    chk("sw exec memReq", ifa.memReq, 0);
    cyc(); ifa.memReady = 1'b1; #1;
    chk("sw mem memReq", ifa.memReq, 1);
    chk("sw mem addrSel", ifa.addrSel, 1);
    chk("sw mem memWe", ifa.memWe, 1);
    chk("sw mem instRetired", a_ret, 1);
    cyc(); ifa.memReady = 1'b0; #1;
    chk("sw next addrSel", ifa.addrSel, 0);
    chk("sw next memWe", ifa.memWe, 0);

    // illegal opcode, TRAP_HALT=0: single TRAP cycle then FETCH
    op = 5'b11111; funct3 = 3'b000; ifa.memReady = 1'b1; #1;
    cyc(); ifa.memReady = 1'b0; #1;
    chk("ill dec illegalOp", a_ill, 0);
    cyc();
    chk("ill trap illegalOp", a_ill, 1);
    chk("ill trap memReq", ifa.memReq, 0);
    chk("ill trap busErr", a_berr, 0);
    cyc();
    chk("ill next memReq", ifa.memReq, 1);
    chk("ill next illegalOp", a_ill, 0);

    // FETCH timeout: cycles 0..3 waiting, busErr in cycle 4
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fto wait%0d busErr", k), a_berr, 0);
      chk($sformatf("fto wait%0d memReq", k), ifa.memReq, 1);
      cyc();
    end
    chk("fto trap busErr", a_berr, 1);
    chk("fto trap illegalOp", a_ill, 0);
    chk("fto trap memReq", ifa.memReq, 0);
    cyc();
    chk("fto next busErr", a_berr, 0);
    // memReady exactly on the last wait cycle: no trap
    op = 5'b00100; funct3 = 3'b000;
    repeat (3) cyc();
    ifa.memReady = 1'b1; #1;
    chk("fto edge irWrite", a_irWrite, 1);
    cyc(); ifa.memReady = 1'b0; #1;
    chk("fto edge busErr", a_berr, 0);
    chk("fto edge immCntrl", a_imm, 2);
    repeat (3) cyc();

    // lw with memory never ready in MEM
    op = 5'b00000; funct3 = 3'b010; ifa.memReady = 1'b1; #1;
    cyc(); ifa.memReady = 1'b0; #1;
    cyc(); cyc();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mto wait%0d addrSel", k), ifa.addrSel, 1);
      chk($sformatf("mto wait%0d busErr", k), a_berr, 0);
      cyc();
    end
    chk("mto trap busErr", a_berr, 1);
    chk("mto trap regWrite", a_regWrite, 0);
    cyc();
    chk("mto next memReq", ifa.memReq, 1);

    // reset in the middle of a store
    op = 5'b01000; funct3 = 3'b010; ifa.memReady = 1'b1; #1;
    cyc(); ifa.memReady = 1'b0; #1;
    cyc(); cyc();
    chk("rststore mem memWe", ifa.memWe, 1);
    rsta = 1'b1; ifa.memReady = 1'b1; #1;
    chk("rststore rst instRetired", a_ret, 0);
    cyc();
    chk("rststore after memWe", ifa.memWe, 0);
    chk("rststore after memReq", ifa.memReq, 1);
    chk("rststore after addrSel", ifa.addrSel, 0);
    chk("rststore after instRetired", a_ret, 0);
    chk("rststore after irWrite", a_irWrite, 0);
    rsta = 1'b0; ifa.memReady = 1'b0; #1;

    // SYSTEM opcode, funct3 001
    op = 5'b11100; funct3 = 3'b001; ifa.memReady = 1'b1; #1;
    cyc(); ifa.memReady = 1'b0; #1;
`ifdef MCU_CSR_EN
    chk("csr dec immCntrl", a_imm, 2);
    chk("csr dec aluSrcB", a_aluSrcB, 1);
    cyc(); cyc();
    chk("csr wb regWrite", a_regWrite, 1);
    chk("csr wb regSrc", a_regSrc, 3);
    chk("csr wb instRetired", a_ret, 1);
    cyc();
    funct3 = 3'b000; ifa.memReady = 1'b1; #1;
    cyc(); ifa.memReady = 1'b0; #1;
    cyc();
    chk("ecall exec illegalOp", a_ill, 0);
    cyc();
    chk("ecall trap illegalOp", a_ill, 1);
    chk("ecall trap regWrite", a_regWrite, 0);
    cyc();
`else
    chk("csr dec illegalOp", a_ill, 0);
    cyc();
    chk("csr trap illegalOp", a_ill, 1);
    chk("csr trap memReq", ifa.memReq, 0);
    cyc();
`endif
    chk("sys next memReq", ifa.memReq, 1);
    rsta = 1'b1;

    // dut B: lw with 3 wait cycles in MEM
    rstb = 1'b0;
    op = 5'b00000; funct3 = 3'b010; ifb.memReady = 1'b1; #1;
    chk("lw fetch irWrite", b_irWrite, 1);
    cyc(); ifb.memReady = 1'b0; #1;
    chk("lw dec immCntrl", b_imm, 2);
    chk("lw dec aluSrcB", b_aluSrcB, 1);
    cyc();
    chk("lw exec memReq", ifb.memReq, 0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("lw wait%0d memReq", k), ifb.memReq, 1);
      chk($sformatf("lw wait%0d memWe", k), ifb.memWe, 0);
      chk($sformatf("lw wait%0d regWrite", k), b_regWrite, 0);
      cyc();
    end
    ifb.memReady = 1'b1; #1;
    chk("lw ready memReq", ifb.memReq, 1);
    chk("lw ready instRetired", b_ret, 0);
    cyc(); ifb.memReady = 1'b0; #1;
    chk("lw wb regWrite", b_regWrite, 1);
    chk("lw wb regSrc", b_regSrc, 1);
    chk("lw wb instRetired", b_ret, 1);
    chk("lw wb memReq", ifb.memReq, 0);
    cyc();
    chk("lw next memReq", ifb.memReq, 1);

    // dut B: counter restarts on MEM entry; ready on the last wait cycle wins
    op = 5'b01000; funct3 = 3'b010;
    repeat (5) cyc();
    ifb.memReady = 1'b1; #1;
    chk("swlong fetch irWrite", b_irWrite, 1);
    cyc(); ifb.memReady = 1'b0; #1;
    cyc(); cyc();
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("swlong wait%0d memReq", k), ifb.memReq, 1);
      cyc();
    end
    ifb.memReady = 1'b1; #1;
    chk("swlong edge instRetired", b_ret, 1);
    chk("swlong edge memWe", ifb.memWe, 1);
    cyc(); ifb.memReady = 1'b0; #1;
    chk("swlong next busErr", b_berr, 0);
    chk("swlong next memReq", ifb.memReq, 1);

    // dut B: illegal opcode with TRAP_HALT=1 stays in TRAP until reset
    op = 5'b11111; funct3 = 3'b000; ifb.memReady = 1'b1; #1;
    cyc(); ifb.memReady = 1'b0; #1;
    cyc();
    chk("halt trap illegalOp", b_ill, 1);
    chk("halt trap memReq", ifb.memReq, 0);
    cyc();
    chk("halt hold illegalOp", b_ill, 0);
    chk("halt hold memReq", ifb.memReq, 0);
    ifb.memReady = 1'b1; #1;
    cyc();
    chk("halt hold2 memReq", ifb.memReq, 0);
    chk("halt hold2 irWrite", b_irWrite, 0);
    rstb = 1'b1;
    cyc();
    chk("halt rst memReq", ifb.memReq, 1);
    chk("halt rst illegalOp", b_ill, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
